// File: rtl/ram_bytewise_sync_pkg.sv
// Shared types and helpers for the byte-addressed data RAM.
package ram_bytewise_sync_pkg;

   localparam int NUM_LANES = 4;   // bytes in the widest access
   localparam int DATA_W    = 32;
   localparam int CNT_W     = 4;   // wait-state counter, LATENCY up to 15

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10,
      RSVD = 2'b11
   } access_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;

   // control fields of a request, captured together in IDLE
   typedef struct packed {
      logic         rw;
      access_size_t size;
      logic         sign_ext;
   } req_ctl_t;

   // number of bytes moved by an access; reserved encodes as 0
   function automatic logic [2:0] size_bytes(access_size_t s);
      case (s)
         BYTE:    return 3'd1;
         HALF:    return 3'd2;
         WORD:    return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   // lane i addresses mem[a+i]; lane 0 always carries the MSB
   function automatic logic [NUM_LANES-1:0] lane_mask(access_size_t s);
      case (s)
         BYTE:    return 4'b0001;
         HALF:    return 4'b0011;
         WORD:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/ram_bytewise_sync_if.sv
// mv/moc request bus between the CPU controller and the data RAM.
interface ram_bytewise_sync_if #(
   parameter int ADDR_W = 32
);
   import ram_bytewise_sync_pkg::*;

   logic              mv;
   logic              rw;
   logic [1:0]        type_data;
   logic              sign_ext;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              moc;
   logic              err;

   modport master (
      output mv, rw, type_data, sign_ext, address, data_in,
      input  data_out, moc, err
   );

   modport slave (
      input  mv, rw, type_data, sign_ext, address, data_in,
      output data_out, moc, err
   );

endinterface

// File: rtl/ram_bytewise_sync_byte_mem_array.sv
// DEPTH x 8 byte storage with four consecutive-address lanes.
// Lane i reads and writes mem[addr+i]; the index wraps inside the array,
// the caller is responsible for rejecting accesses that cross the top.
module ram_bytewise_sync_byte_mem_array
   import ram_bytewise_sync_pkg::*;
#(
   parameter int DEPTH = 256,
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic [IW-1:0]              addr,
   input  logic [NUM_LANES-1:0]       we,
   input  logic [NUM_LANES-1:0][7:0]  wdata,
   output logic [NUM_LANES-1:0][7:0]  rdata
);

   logic [7:0]                  mem [DEPTH];
   logic [NUM_LANES-1:0][IW-1:0] lane_addr;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_addr[g] = addr + IW'(g);
      assign rdata[g]     = mem[lane_addr[g]];
   end

   // commit all enabled lanes in the same cycle
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (we[i]) mem[lane_addr[i]] <= wdata[i];
      end
   end

endmodule

// File: rtl/ram_bytewise_sync.sv
// Byte-addressed big-endian data RAM with mv/moc handshake, programmable
// wait states, signed loads and misalignment / range error reporting.
module ram_bytewise_sync
   import ram_bytewise_sync_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 32,
   parameter int LATENCY     = 1,
   parameter int ALIGN_CHECK = 1
) (
   input  logic                clk,
   input  logic                reset,
   ram_bytewise_sync_if.slave  bus
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

   state_t                      state;
   logic [CNT_W-1:0]            cnt;
   req_ctl_t                    ctl_q;
   logic [ADDR_W-1:0]           addr_q;
   logic [DATA_W-1:0]           wdat_q;
   logic                        err_pend;
   logic                        moc_q;
   logic                        err_q;
   logic [DATA_W-1:0]           dout_q;

   req_ctl_t                    cur_ctl;
   logic [ADDR_W-1:0]           cur_addr;
   logic [DATA_W-1:0]           cur_wdat;
   logic [2:0]                  n_bytes;
   logic [IW:0]                 end_addr;
   logic                        out_of_range;
   logic                        misaligned;
   logic                        acc_err;
   logic                        do_access;
   logic                        wr_commit;
   logic [NUM_LANES-1:0]        lane_en;
   logic [NUM_LANES-1:0]        lane_we;
   logic [NUM_LANES-1:0][7:0]   lane_wdata;
   logic [NUM_LANES-1:0][7:0]   rdata;
   logic [DATA_W-1:0]           wdat_lj;
   logic [DATA_W-1:0]           rd_be;
   logic [DATA_W-1:0]           rd_ext;

   assign bus.moc      = moc_q;
   assign bus.err      = err_q;
   assign bus.data_out = dout_q;

   // live bus in IDLE (only used directly when LATENCY is 0), captured copy otherwise
   always_comb begin
      if (state == IDLE) begin
         cur_ctl.rw       = bus.rw;
         cur_ctl.size     = access_size_t'(bus.type_data);
         cur_ctl.sign_ext = bus.sign_ext;
         cur_addr         = bus.address;
         cur_wdat         = bus.data_in;
      end else begin
         cur_ctl          = ctl_q;
         cur_addr         = addr_q;
         cur_wdat         = wdat_q;
      end
   end

   // reject reserved size, accesses crossing the top, and misaligned half/word
   always_comb begin
      n_bytes      = size_bytes(cur_ctl.size);
      end_addr     = {1'b0, cur_addr[IW-1:0]} + (IW+1)'(n_bytes) - (IW+1)'(1);
      out_of_range = ((cur_addr >> IW) != '0) || end_addr[IW];
      misaligned   = 1'b0;
      if (ALIGN_CHECK != 0) begin
         misaligned = ((cur_ctl.size == HALF) && cur_addr[0]) ||
                      ((cur_ctl.size == WORD) && (cur_addr[1:0] != 2'b00));
      end
      acc_err      = (cur_ctl.size == RSVD) || out_of_range || misaligned;
   end

   // the access happens on the capture edge for LATENCY 0, else on the last wait cycle;
   // a reset on that same edge aborts it
   assign do_access = !reset &&
                      (((state == IDLE) && bus.mv && (LATENCY == 0)) ||
                       ((state == WAIT) && (cnt == LAST_CNT)));
   assign wr_commit = do_access && !acc_err && !cur_ctl.rw;
   assign lane_en   = lane_mask(cur_ctl.size);

   // left-justify write data so lane 0 always receives the access MSB
   always_comb begin
      case (cur_ctl.size)
         BYTE:    wdat_lj = {cur_wdat[7:0], 24'h0};
         HALF:    wdat_lj = {cur_wdat[15:0], 16'h0};
         default: wdat_lj = cur_wdat;
      endcase
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_wdata[g]              = wdat_lj[DATA_W-1-8*g -: 8];
      assign lane_we[g]                 = wr_commit && lane_en[g];
      assign rd_be[DATA_W-1-8*g -: 8]   = rdata[g];
   end

   // right-justify read data and fill the upper bits with zeros or the sign
   always_comb begin
      case (cur_ctl.size)
         BYTE:    rd_ext = {{24{cur_ctl.sign_ext & rd_be[31]}}, rd_be[31:24]};
         HALF:    rd_ext = {{16{cur_ctl.sign_ext & rd_be[31]}}, rd_be[31:16]};
         default: rd_ext = rd_be;
      endcase
   end

   ram_bytewise_sync_byte_mem_array #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .addr  (cur_addr[IW-1:0]),
      .we    (lane_we),
      .wdata (lane_wdata),
      .rdata (rdata)
   );

   // handshake FSM: capture, wait states, complete, wait for mv to drop
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         ctl_q    <= '0;
         addr_q   <= '0;
         wdat_q   <= '0;
         err_pend <= 1'b0;
         moc_q    <= 1'b0;
         err_q    <= 1'b0;
         dout_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.mv) begin
                  ctl_q  <= cur_ctl;
                  addr_q <= bus.address;
                  wdat_q <= bus.data_in;
                  cnt    <= '0;
                  if (LATENCY == 0) begin
                     err_pend <= acc_err;
                     if (cur_ctl.rw && !acc_err) dout_q <= rd_ext;
                     state <= DONE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == LAST_CNT) begin
                  err_pend <= acc_err;
                  if (cur_ctl.rw && !acc_err) dout_q <= rd_ext;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               // raise moc once, then hold it until the controller drops mv
               if (!moc_q) begin
                  moc_q <= 1'b1;
                  err_q <= err_pend;
               end else if (!bus.mv) begin
                  moc_q <= 1'b0;
                  err_q <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
